// File: rtl/ggx_rng_pkg.sv
// ggx_rng_pkg: xorshift64 constants, step/pack helpers and FSM states for axis_uniform_rng
package ggx_rng_pkg;

    localparam logic [63:0] DEFAULT_SEED = 64'h9E3779B97F4A7C15;
    localparam int XS_A = 13;
    localparam int XS_B = 7;
    localparam int XS_C = 17;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } rng_state_e;

    function automatic logic [63:0] xorshift64_step(input logic [63:0] x);
        logic [63:0] y;
        y = x ^ (x << XS_A);
        y = y ^ (y >> XS_B);
        y = y ^ (y << XS_C);
        return y;
    endfunction

    // Each uniform is the top frac_bits of its 32-bit half; u0 lands low, u1 above it.
    function automatic logic [63:0] pack_uniform(input logic [63:0] x, input int frac_bits);
        logic [63:0] u0;
        logic [63:0] u1;
        u0 = {32'd0, x[31:0]} >> (32 - frac_bits);
        u1 = {32'd0, x[63:32]} >> (32 - frac_bits);
        return u0 | (u1 << frac_bits);
    endfunction

endpackage

// File: rtl/axis_uniform_rng.sv
// axis_uniform_rng: AXI-Stream source of uniform (u0,u1) pairs from a backpressure-aware xorshift64
// Ports: m00_axis_aclk/m00_axis_areset (async, active-high); seed, seed_load, start, stop, num_samples
// control a run; busy, done, sample_count report it; m00_axis_* is the AXI-Stream master.
// Build option: define RNG_OPEN_INTERVAL_EN to force the LSB of u0 and u1 to 1 (never zero).
module axis_uniform_rng
    import ggx_rng_pkg::*;
#(
    parameter int FRAC_BITS              = 32,
    parameter int C_M00_AXIS_TDATA_WIDTH = 2*FRAC_BITS,
    parameter int FRAME_LEN              = 256,
    parameter int CNT_BITS               = 32
) (
    input  logic                                  m00_axis_aclk,
    input  logic                                  m00_axis_areset,
    input  logic [63:0]                           seed,
    input  logic                                  seed_load,
    input  logic                                  start,
    input  logic                                  stop,
    input  logic [CNT_BITS-1:0]                   num_samples,
    output logic                                  busy,
    output logic                                  done,
    output logic [CNT_BITS-1:0]                   sample_count,
    output logic                                  m00_axis_tvalid,
    input  logic                                  m00_axis_tready,
    output logic [C_M00_AXIS_TDATA_WIDTH-1:0]     m00_axis_tdata,
    output logic                                  m00_axis_tlast,
    output logic [C_M00_AXIS_TDATA_WIDTH/8-1:0]   m00_axis_tstrb
);

    localparam int W  = C_M00_AXIS_TDATA_WIDTH;
    localparam int FW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam logic [FW-1:0] FRAME_LAST = FW'(FRAME_LEN - 1);

    rng_state_e          fsm;
    logic [63:0]         gen;
    logic [63:0]         gen_src;
    logic [63:0]         gen_nxt;
    logic [W-1:0]        load_data;
    logic [CNT_BITS-1:0] num_lat;
    logic [CNT_BITS-1:0] cnt_inc;
    logic [FW-1:0]       frame_cnt;
    logic [FW-1:0]       frame_nxt;
    logic                stop_pending;
    logic                hs;
    logic                last_beat;
    logic                next_final;

    assign m00_axis_tstrb = '1;

    always_comb begin
        // A seed_load in IDLE feeds the step directly so a coincident start uses the new seed.
        gen_src    = (fsm == ST_IDLE && seed_load) ? ((seed == '0) ? DEFAULT_SEED : seed) : gen;
        gen_nxt    = xorshift64_step(gen_src);
        load_data  = W'(pack_uniform(gen_nxt, FRAC_BITS));
`ifdef RNG_OPEN_INTERVAL_EN
        load_data  = load_data | W'((64'd1 << FRAC_BITS) | 64'd1);
`endif
        hs         = m00_axis_tvalid && m00_axis_tready;
        cnt_inc    = sample_count + CNT_BITS'(1);
        frame_nxt  = (frame_cnt == FRAME_LAST) ? '0 : frame_cnt + FW'(1);
        last_beat  = (num_lat != '0 && cnt_inc == num_lat) || stop_pending || stop;
        // The beat about to be loaded is number cnt_inc+1 of the run.
        next_final = (num_lat != '0) && (cnt_inc + CNT_BITS'(1) == num_lat);
    end

    always_ff @(posedge m00_axis_aclk or posedge m00_axis_areset) begin
        if (m00_axis_areset) begin
            fsm             <= ST_IDLE;
            gen             <= DEFAULT_SEED;
            m00_axis_tvalid <= 1'b0;
            m00_axis_tdata  <= '0;
            m00_axis_tlast  <= 1'b0;
            busy            <= 1'b0;
            done            <= 1'b0;
            sample_count    <= '0;
            frame_cnt       <= '0;
            num_lat         <= '0;
            stop_pending    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (fsm)
                ST_IDLE: begin
                    if (start) begin
                        gen             <= gen_nxt;
                        m00_axis_tdata  <= load_data;
                        m00_axis_tvalid <= 1'b1;
                        m00_axis_tlast  <= (FRAME_LAST == '0) || (num_samples == CNT_BITS'(1));
                        num_lat         <= num_samples;
                        sample_count    <= '0;
                        frame_cnt       <= '0;
                        stop_pending    <= 1'b0;
                        busy            <= 1'b1;
                        fsm             <= ST_RUN;
                    end else if (seed_load) begin
                        gen <= gen_src;
                    end
                end
                ST_RUN: begin
                    if (stop) stop_pending <= 1'b1;
                    if (hs) begin
                        sample_count <= cnt_inc;
                        frame_cnt    <= frame_nxt;
                        if (last_beat) begin
                            m00_axis_tvalid <= 1'b0;
                            m00_axis_tlast  <= 1'b0;
                            busy            <= 1'b0;
                            done            <= 1'b1;
                            fsm             <= ST_DONE;
                        end else begin
                            gen            <= gen_nxt;
                            m00_axis_tdata <= load_data;
                            m00_axis_tlast <= (frame_nxt == FRAME_LAST) || next_final;
                        end
                    end
                end
                default: fsm <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axis_uniform_rng.sv
// tb_axis_uniform_rng: scoreboard bench for axis_uniform_rng (FRAME_LEN=2)
module tb_axis_uniform_rng;

    localparam int FL = 2;
    localparam logic [63:0] DEF = 64'h9E3779B97F4A7C15;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [63:0] seed;
    logic        seed_load;
    logic        start;
    logic        stop;
    logic [31:0] num_samples;
    logic        busy;
    logic        done;
    logic [31:0] sample_count;
    logic        tvalid;
    logic        tready;
    logic [63:0] tdata;
    logic        tlast;
    logic [7:0]  tstrb;

    axis_uniform_rng #(.FRAC_BITS(32), .C_M00_AXIS_TDATA_WIDTH(64), .FRAME_LEN(FL), .CNT_BITS(32)) dut (
        .m00_axis_aclk(clk),
        .m00_axis_areset(rst),
        .seed(seed),
        .seed_load(seed_load),
        .start(start),
        .stop(stop),
        .num_samples(num_samples),
        .busy(busy),
        .done(done),
        .sample_count(sample_count),
        .m00_axis_tvalid(tvalid),
        .m00_axis_tready(tready),
        .m00_axis_tdata(tdata),
        .m00_axis_tlast(tlast),
        .m00_axis_tstrb(tstrb)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int beats = 0;
    int dones = 0;
    int busy_cyc = 0;
    logic [64:0] exp_q[$];
    logic [64:0] held;
    logic [64:0] want;
    logic        holding = 1'b0;
    logic [31:0] tl_hist = '0;
    logic [63:0] ms;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic logic [63:0] xs(input logic [63:0] x);
        logic [63:0] y;
        y = x ^ (x << 13);
        y = y ^ (y >> 7);
        y = y ^ (y << 17);
        return y;
    endfunction

    function automatic logic [63:0] pk(input logic [63:0] x);
`ifdef RNG_OPEN_INTERVAL_EN
        return x | 64'h0000_0001_0000_0001;
`else
        return x;
`endif
    endfunction

    task automatic push_run(input int n, input int num);
        for (int i = 0; i < n; i++) begin
            ms = xs(ms);
            exp_q.push_back({((i % FL) == FL - 1) || (num != 0 && i + 1 == num), pk(ms)});
        end
    endtask

    // Monitor: stall stability and in-order scoreboard pop on every handshake.
    always @(negedge clk) begin
        if (busy) busy_cyc++;
        if (done) dones++;
        if (holding && tvalid) chk("hold_stable", {tlast, tdata}, held);
        holding = tvalid && !tready;
        held = {tlast, tdata};
        if (tvalid && tready) begin
            beats++;
            tl_hist = {tl_hist[30:0], tlast};
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL extra_beat: got %h want none", tdata);
            end else begin
                want = exp_q.pop_front();
                chk("beat", {tlast, tdata}, want);
            end
        end
    end

    task automatic go(input logic [31:0] n, input logic ld, input logic [63:0] sd);
        seed = sd;
        seed_load = ld;
        num_samples = n;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        seed_load = 1'b0;
    endtask

    task automatic wait_done(input string nm);
        int d0;
        int n;
        d0 = dones;
        n = 0;
        while (dones == d0 && n < 5000) begin
            @(posedge clk);
            n++;
        end
        if (dones == d0) begin
            total++;
            bad++;
            $display("FAIL %s_timeout: got no done want done", nm);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        int b0;
        int acc;
        int it;
        logic hs;
        seed = '0;
        seed_load = 1'b0;
        start = 1'b0;
        stop = 1'b0;
        num_samples = '0;
        tready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_tvalid", tvalid, 0);
        chk("rst_tdata", tdata, 0);
        chk("rst_tlast", tlast, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_count", sample_count, 0);
        chk("tstrb", tstrb, 8'hFF);
        rst = 1'b0;
        @(posedge clk); #1;

        // Seed 1, single beat, hand-computed value.
        seed = 64'h1;
        seed_load = 1'b1;
        @(posedge clk); #1;
        seed_load = 1'b0;
        exp_q.push_back({1'b1, pk(64'h00000000_40822041)});
        ms = 64'h00000000_40822041;
        tready = 1'b1;
        go(1, 1'b0, 64'h0);
        @(posedge clk); #1;
        chk("t1_done", done, 1);
        chk("t1_busy", busy, 0);
        chk("t1_tvalid", tvalid, 0);
        chk("t1_count", sample_count, 1);
        @(posedge clk); #1;
        chk("t1_done_pulse", done, 0);

        // Zero seed with coincident start: DEFAULT_SEED substitution.
        ms = DEF;
        push_run(1, 1);
        go(1, 1'b1, 64'h0);
        wait_done("zero_seed");
        chk("t2_q_empty", exp_q.size(), 0);

        // Frames of 2 over a 5-beat run.
        d0 = dones;
        b0 = busy_cyc;
        push_run(5, 5);
        go(5, 1'b0, 64'h0);
        wait_done("frames");
        chk("t3_tlast_pattern", tl_hist[4:0], 5'b01011);
        chk("t3_busy_cycles", busy_cyc - b0, 5);
        chk("t3_done_count", dones - d0, 1);
        chk("t3_count", sample_count, 5);
        chk("t3_q_empty", exp_q.size(), 0);

        // Random backpressure, unbounded run, stop coincident with the 1000th handshake.
        push_run(1000, 0);
        tready = 1'b0;
        go(0, 1'b0, 64'h0);
        acc = 0;
        it = 0;
        while (acc < 1000 && it < 20000) begin
            tready = ($urandom_range(0, 9) < 3);
            stop = tready && (acc == 999);
            @(negedge clk);
            hs = tvalid && tready;
            @(posedge clk); #1;
            stop = 1'b0;
            if (hs) acc++;
            it++;
        end
        tready = 1'b0;
        chk("t4_accepted", acc, 1000);
        wait_done("backpressure");
        chk("t4_count", sample_count, 1000);
        chk("t4_tvalid", tvalid, 0);
        chk("t4_q_empty", exp_q.size(), 0);

        // Stop while stalled: in-flight beat still delivered.
        d0 = dones;
        push_run(1, 0);
        go(0, 1'b0, 64'h0);
        @(posedge clk); #1;
        stop = 1'b1;
        @(posedge clk); #1;
        stop = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
        end
        chk("t5_still_valid", tvalid, 1);
        tready = 1'b1;
        wait_done("stall_stop");
        chk("t5_count", sample_count, 1);
        chk("t5_tvalid", tvalid, 0);
        chk("t5_done_count", dones - d0, 1);
        chk("t5_q_empty", exp_q.size(), 0);

        // Asynchronous reset mid-run.
        tready = 1'b0;
        go(0, 1'b0, 64'h0);
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        chk("t6_tvalid", tvalid, 0);
        chk("t6_tdata", tdata, 0);
        chk("t6_tlast", tlast, 0);
        chk("t6_busy", busy, 0);
        chk("t6_done", done, 0);
        chk("t6_count", sample_count, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        ms = DEF;
        push_run(2, 2);
        tready = 1'b1;
        go(2, 1'b0, 64'h0);
        wait_done("after_reset");
        chk("t6_count2", sample_count, 2);
        chk("t6_q_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
